// File: rtl/alu_md.sv
// MIPS-style ALU with a multi-cycle multiply/divide unit and HI/LO registers.
// Multiply is shift-add and divide is restoring; each processes one bit per cycle on magnitudes.
module alu_md #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [4:0]       ALUop,
    input  logic [SHW-1:0]   shf,
    input  logic             start,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic             Overflow,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam logic [4:0] OP_ADD = 5'b00000, OP_ADDU = 5'b00001, OP_SUB = 5'b00010,
        OP_SUBU = 5'b00011, OP_SLTU = 5'b00100, OP_SLT = 5'b00101, OP_AND = 5'b00110,
        OP_NOR = 5'b00111, OP_OR = 5'b01000, OP_XOR = 5'b01001, OP_SLL = 5'b01010,
        OP_SLLV = 5'b01011, OP_SRA = 5'b01100, OP_SRAV = 5'b01101, OP_SRL = 5'b01110,
        OP_SRLV = 5'b01111, OP_LUI = 5'b10001, OP_PASSA = 5'b10010, OP_MULT = 5'b10100,
        OP_MULTU = 5'b10101, OP_DIV = 5'b10110, OP_DIVU = 5'b10111, OP_MFHI = 5'b11000,
        OP_MFLO = 5'b11001, OP_MTHI = 5'b11010, OP_MTLO = 5'b11011;
    localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] hi_q, lo_q, acc_q, low_q, opb_q, a_q;
    logic [SHW-1:0]   cnt_q;
    logic             done_q, neg_res_q, neg_rem_q, div0_q, is_div_q;

    logic [WIDTH-1:0] sum, diff, res;
    logic             ovf;

    assign sum  = A + B;
    assign diff = A - B;

    always_comb begin
        res = '0;
        ovf = 1'b0;
        case (ALUop)
            OP_ADD: begin
                res = sum;
                ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_ADDU:  res = sum;
            OP_SUB: begin
                res = diff;
                ovf = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUBU:  res = diff;
            OP_SLTU:  res = {{(WIDTH-1){1'b0}}, (A < B)};
            OP_SLT:   res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_AND:   res = A & B;
            OP_NOR:   res = ~(A | B);
            OP_OR:    res = A | B;
            OP_XOR:   res = A ^ B;
            OP_SLL:   res = B << shf;
            OP_SLLV:  res = B << A[SHW-1:0];
            OP_SRA:   res = $signed(B) >>> shf;
            OP_SRAV:  res = $signed(B) >>> A[SHW-1:0];
            OP_SRL:   res = B >> shf;
            OP_SRLV:  res = B >> A[SHW-1:0];
            OP_LUI:   res = B << (WIDTH / 2);
            OP_PASSA: res = A;
            OP_MFHI:  res = hi_q;
            OP_MFLO:  res = lo_q;
            default:  res = '0;
        endcase
    end

    assign Result   = res;
    assign Zero     = (res == '0);
    assign Overflow = ovf;
    assign hi       = hi_q;
    assign lo       = lo_q;
    assign done     = done_q;

    logic is_mul_op, is_div_op, signed_op, a_neg, b_neg;
    assign is_mul_op = (ALUop == OP_MULT) || (ALUop == OP_MULTU);
    assign is_div_op = (ALUop == OP_DIV) || (ALUop == OP_DIVU);
    assign signed_op = ~ALUop[0];
    assign a_neg     = signed_op & A[WIDTH-1];
    assign b_neg     = signed_op & B[WIDTH-1];

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start && is_mul_op)      state_d = MUL;
                else if (start && is_div_op) state_d = DIV;
            end
            MUL, DIV: if (cnt_q == LAST) state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    logic launch, step_mul, step_div, finish;
    always_comb begin
        busy     = (state_q != IDLE);
        launch   = (state_q == IDLE) && start;
        step_mul = (state_q == MUL);
        step_div = (state_q == DIV);
        finish   = (state_q == FIN);
    end

    // Multiply: {acc,low} holds partial product over the shrinking multiplier.
    // Divide: acc is the partial remainder, low shifts dividend out and quotient in.
    logic [WIDTH:0]     madd, rsh, trial;
    logic [2*WIDTH-1:0] prod, prod_neg;
    assign madd     = {1'b0, acc_q} + {1'b0, (low_q[0] ? opb_q : '0)};
    assign rsh      = {acc_q, low_q[WIDTH-1]};
    assign trial    = rsh - {1'b0, opb_q};
    assign prod     = {acc_q, low_q};
    assign prod_neg = -prod;

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q <= '0; lo_q <= '0; acc_q <= '0; low_q <= '0; opb_q <= '0; a_q <= '0;
            cnt_q <= '0; done_q <= 1'b0; neg_res_q <= 1'b0; neg_rem_q <= 1'b0;
            div0_q <= 1'b0; is_div_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (launch) begin
                if (is_mul_op || is_div_op) begin
                    a_q       <= A;
                    low_q     <= a_neg ? -A : A;
                    opb_q     <= b_neg ? -B : B;
                    acc_q     <= '0;
                    cnt_q     <= '0;
                    neg_res_q <= a_neg ^ b_neg;
                    neg_rem_q <= a_neg;
                    div0_q    <= (B == '0);
                    is_div_q  <= is_div_op;
                end else if (ALUop == OP_MTHI) begin
                    hi_q   <= A;
                    done_q <= 1'b1;
                end else if (ALUop == OP_MTLO) begin
                    lo_q   <= A;
                    done_q <= 1'b1;
                end
            end
            if (step_mul) begin
                acc_q <= madd[WIDTH:1];
                low_q <= {madd[0], low_q[WIDTH-1:1]};
                cnt_q <= cnt_q + SHW'(1);
            end
            if (step_div) begin
                acc_q <= (rsh >= {1'b0, opb_q}) ? trial[WIDTH-1:0] : rsh[WIDTH-1:0];
                low_q <= {low_q[WIDTH-2:0], (rsh >= {1'b0, opb_q})};
                cnt_q <= cnt_q + SHW'(1);
            end
            if (finish) begin
                done_q <= 1'b1;
                if (!is_div_q) begin
                    {hi_q, lo_q} <= neg_res_q ? prod_neg : prod;
                end else if (div0_q) begin
                    hi_q <= a_q;
                    lo_q <= '1;
                end else begin
                    lo_q <= neg_res_q ? -low_q : low_q;
                    hi_q <= neg_rem_q ? -acc_q : acc_q;
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_md.sv
// Directed bench for alu_md: combinational vector table plus multi-cycle HI/LO sequences.
module tb_alu_md;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] A = '0, B = '0;
    logic [4:0]  ALUop = '0;
    logic [4:0]  shf = '0;
    logic        start = 1'b0;
    logic [31:0] Result, hi, lo;
    logic        Zero, Overflow, busy, done;

    int checks = 0;
    int errors = 0;

    alu_md #(.WIDTH(32), .SHW(5)) dut (
        .clk(clk), .rst(rst), .A(A), .B(B), .ALUop(ALUop), .shf(shf), .start(start),
        .Result(Result), .Zero(Zero), .Overflow(Overflow), .busy(busy), .done(done),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
        logic [31:0] res;
        logic        z;
        logic        o;
    } vec_t;

    vec_t vecs[22];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s = %h", name, act);
        end
    endtask

    // Launch a HI/LO op, count busy cycles, optionally poke a second start mid-flight.
    task automatic run_md(input string name, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                          input bit inject);
        int n;
        @(negedge clk);
        ALUop = op; A = a; B = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            if (inject && n == 5) begin
                ALUop = 5'b10111; A = 32'd100; B = 32'd3; start = 1'b1;
            end else begin
                ALUop = op; A = a; B = b; start = 1'b0;
            end
            @(negedge clk);
        end
        check({name, " busy_cycles"}, 64'(n), 64'd33);
        check({name, " done"}, 64'(done), 64'd1);
        check({name, " hi/lo"}, {hi, lo}, {ehi, elo});
    endtask

    initial begin
        int quiet;
        vecs[0]  = '{"ADD ovf",    5'b00000, 32'h7FFFFFFF, 32'h1,        5'd0,  32'h80000000, 1'b0, 1'b1};
        vecs[1]  = '{"ADDU",       5'b00001, 32'h7FFFFFFF, 32'h1,        5'd0,  32'h80000000, 1'b0, 1'b0};
        vecs[2]  = '{"SRL",        5'b01110, 32'h0,        32'hF0000000, 5'd4,  32'h0F000000, 1'b0, 1'b0};
        vecs[3]  = '{"SRA",        5'b01100, 32'h0,        32'hF0000000, 5'd4,  32'hFF000000, 1'b0, 1'b0};
        vecs[4]  = '{"SLLV",       5'b01011, 32'd36,       32'h1,        5'd0,  32'h00000010, 1'b0, 1'b0};
        vecs[5]  = '{"SUB ovf",    5'b00010, 32'h80000000, 32'h1,        5'd0,  32'h7FFFFFFF, 1'b0, 1'b1};
        vecs[6]  = '{"SUB zero",   5'b00010, 32'h5,        32'h5,        5'd0,  32'h0,        1'b1, 1'b0};
        vecs[7]  = '{"SLT",        5'b00101, 32'hFFFFFFFF, 32'h1,        5'd0,  32'h1,        1'b0, 1'b0};
        vecs[8]  = '{"SLTU",       5'b00100, 32'hFFFFFFFF, 32'h1,        5'd0,  32'h0,        1'b1, 1'b0};
        vecs[9]  = '{"NOR",        5'b00111, 32'h0,        32'h0,        5'd0,  32'hFFFFFFFF, 1'b0, 1'b0};
        vecs[10] = '{"LUI",        5'b10001, 32'h0,        32'h1234,     5'd0,  32'h12340000, 1'b0, 1'b0};
        vecs[11] = '{"XOR",        5'b01001, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'h0FF00FF0, 1'b0, 1'b0};
        vecs[12] = '{"AND",        5'b00110, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'hF000F000, 1'b0, 1'b0};
        vecs[13] = '{"OR",         5'b01000, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'hFFF0FFF0, 1'b0, 1'b0};
        vecs[14] = '{"PASSA",      5'b10010, 32'hDEADBEEF, 32'h0,        5'd0,  32'hDEADBEEF, 1'b0, 1'b0};
        vecs[15] = '{"illegal op", 5'b10000, 32'h1,        32'h1,        5'd0,  32'h0,        1'b1, 1'b0};
        vecs[16] = '{"SRAV",       5'b01101, 32'd4,        32'h80000000, 5'd0,  32'hF8000000, 1'b0, 1'b0};
        vecs[17] = '{"SRLV",       5'b01111, 32'd4,        32'h80000000, 5'd0,  32'h08000000, 1'b0, 1'b0};
        vecs[18] = '{"SLL 31",     5'b01010, 32'h0,        32'h3,        5'd31, 32'h80000000, 1'b0, 1'b0};
        vecs[19] = '{"SUBU wrap",  5'b00011, 32'h0,        32'h1,        5'd0,  32'hFFFFFFFF, 1'b0, 1'b0};
        vecs[20] = '{"ADD carry",  5'b00000, 32'hFFFFFFFF, 32'h1,        5'd0,  32'h0,        1'b1, 1'b0};
        vecs[21] = '{"SUB ovf2",   5'b00010, 32'h7FFFFFFF, 32'hFFFFFFFF, 5'd0,  32'h80000000, 1'b0, 1'b1};

        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset busy/done", {62'd0, busy, done}, 64'd0);
        check("reset hi/lo", {hi, lo}, 64'd0);

        foreach (vecs[i]) begin
            @(negedge clk);
            ALUop = vecs[i].op; A = vecs[i].a; B = vecs[i].b; shf = vecs[i].sh;
            #1;
            check(vecs[i].name, {30'd0, Zero, Overflow, Result},
                  {30'd0, vecs[i].z, vecs[i].o, vecs[i].res});
        end
        shf = '0;

        run_md("MULT -2*3", 5'b10100, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0);
        ALUop = 5'b11001;
        #1 check("MFLO", 64'(Result), 64'hFFFFFFFA);
        @(negedge clk);
        check("done single pulse", 64'(done), 64'd0);
        ALUop = 5'b11000;
        #1 check("MFHI", 64'(Result), 64'hFFFFFFFF);

        run_md("MULTU max ignore2nd", 5'b10101, 32'hFFFFFFFF, 32'hFFFFFFFF,
               32'hFFFFFFFE, 32'h00000001, 1'b1);
        run_md("DIV -7/2", 5'b10110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        run_md("DIV 7/-2", 5'b10110, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0);
        run_md("DIV min/-1", 5'b10110, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0);
        run_md("DIVU 100/7", 5'b10111, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
        run_md("DIVU 7/0", 5'b10111, 32'd7, 32'd0, 32'd7, 32'hFFFFFFFF, 1'b0);

        // New start in the done cycle must be accepted.
        ALUop = 5'b11011; A = 32'h55; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("MTLO in done cycle", {31'd0, done, lo}, {31'd0, 1'b1, 32'h55});

        @(negedge clk);
        ALUop = 5'b11010; A = 32'h1234; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("MTHI hi/busy/done", {30'd0, busy, done, hi}, {30'd0, 1'b0, 1'b1, 32'h1234});
        @(negedge clk);
        check("MTHI done drop", {62'd0, busy, done}, 64'd0);

        // Reset ten cycles into a MULTU aborts it with no completion pulse.
        ALUop = 5'b10101; A = 32'd5; B = 32'd6; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("MULTU busy before rst", 64'(busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst abort busy/hi/lo", {31'd0, busy, hi}, {31'd0, 1'b0, 32'd0});
        check("rst abort lo", 64'(lo), 64'd0);
        quiet = 0;
        repeat (40) begin
            @(negedge clk);
            if (busy !== 1'b0 || done !== 1'b0) quiet++;
        end
        check("no done after rst", 64'(quiet), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_md.md
ALU_MD -- requirements
Module: alu_md

Interface
REQ-001 Parameter WIDTH, default 32, datapath width in bits; legal values are even and >= 8.
REQ-002 Parameter SHW, default 5, shift-amount width; SHALL equal log2(WIDTH).
REQ-003 Clocking is fixed: one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 A  input  WIDTH  operand A (rs).
REQ-007 B  input  WIDTH  operand B (rt/immediate).
REQ-008 ALUop  input  5  operation select, encoding per REQ-013.
REQ-009 shf  input  SHW  immediate shift amount.
REQ-010 start  input  1  launches a HI/LO operation (MULT/MULTU/DIV/DIVU/MTHI/MTLO).
REQ-011 Result  output  WIDTH  combinational result; Zero  output  1  Result==0; Overflow  output  1  signed overflow.
REQ-012 busy  output  1  multi-cycle op in flight; done  output  1  one-cycle completion pulse; hi, lo  output  WIDTH  HI/LO register contents.

Function
REQ-013 Opcodes: 00000 ADD, 00001 ADDU, 00010 SUB, 00011 SUBU, 00100 SLTU, 00101 SLT, 00110 AND, 00111 NOR, 01000 OR, 01001 XOR, 01010 SLL, 01011 SLLV, 01100 SRA, 01101 SRAV, 01110 SRL, 01111 SRLV, 10001 LUI, 10010 PASSA, 10100 MULT, 10101 MULTU, 10110 DIV, 10111 DIVU, 11000 MFHI, 11001 MFLO, 11010 MTHI, 11011 MTLO; any other code gives Result=0.
REQ-014 Combinational ops complete in the same cycle; Result depends only on A, B, shf, ALUop, HI, LO.
REQ-015 Shifts: SLL/SRA/SRL use shf; SLLV/SRAV/SRLV use A[SHW-1:0]; SRA/SRAV are arithmetic, SRL/SRLV logical.
REQ-016 LUI: Result = B << (WIDTH/2); SLT signed compare, SLTU unsigned, result 1 or 0.
REQ-017 Overflow = 1 only for ADD/SUB on signed two's-complement overflow; Overflow = 0 for every other op. Result still carries the wrapped sum/difference.
REQ-018 Zero = 1 iff Result == 0, for every op.
REQ-019 MFHI/MFLO: Result = HI/LO register value, also while busy; the CPU stalls on busy.
REQ-020 MTHI/MTLO: with start=1 and busy=0, A is written to HI/LO at that edge; busy stays 0; done pulses the next cycle.
REQ-021 FSM states IDLE, MUL, DIV, FIN. IDLE->MUL on start with MULT/MULTU; IDLE->DIV on start with DIV/DIVU; MUL/DIV->FIN after WIDTH iteration cycles; FIN->IDLE unconditionally.
REQ-022 Operands are latched at the start edge. Signed ops convert operands to magnitudes and restore signs in FIN.
REQ-023 Mult: shift-add, one bit per cycle; {HI,LO} = the 2*WIDTH-bit product.
REQ-024 Div: restoring, one bit per cycle; LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
REQ-025 Divide by zero: LO = all ones, HI = A (latched dividend); latency unchanged; no error flag.
REQ-026 DIV of -2^(WIDTH-1) by -1: LO = -2^(WIDTH-1), HI = 0.
REQ-027 Latency: start sampled at edge E0; busy = 1 after E0 through edge E(WIDTH+1); HI/LO written at E(WIDTH+1); done = 1 for the single cycle following that edge; busy = 0 in that cycle.
REQ-028 start while busy = 1 is ignored; start with a non-HI/LO op is ignored.
REQ-029 A new start is accepted in the done cycle.

Reset
REQ-030 rst = 1 at an edge sets state = IDLE, busy = 0, done = 0, HI = 0, LO = 0, and clears iteration counters.
REQ-031 rst mid-operation aborts the operation and discards its result; rst has priority over start.
REQ-032 Combinational outputs have no reset dependency beyond HI/LO.

Verification (WIDTH = 32)
REQ-033 ADD A=0x7FFFFFFF, B=1 -> Result=0x80000000, Overflow=1, Zero=0; ADDU with the same operands -> Overflow=0.
REQ-034 SRL shf=4, B=0xF0000000 -> 0x0F000000; SRA with the same inputs -> 0xFF000000; SLLV A=36, B=1 -> 0x00000010.
REQ-035 MULT A=0xFFFFFFFE (-2), B=3 -> busy for 33 cycles, done pulse, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; MFLO then gives Result=0xFFFFFFFA.
REQ-036 DIV A=-7, B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU A=7, B=0 -> LO=0xFFFFFFFF, HI=7.
REQ-037 Second start during busy -> ignored, first result intact; rst at cycle 10 of MULTU -> busy=0, HI=LO=0, no done pulse.
REQ-038 MTHI A=0x1234 with start -> hi=0x1234 next cycle, busy never asserted, done pulses once.
